// File: rtl/i2c_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_tx_queue
//  Description : Circular-buffer queue of {address, data} entries feeding an
//                I2C master. Issues one entry at a time, waits for the master
//                to report busy and then idle, and enforces an idle gap
//                between transactions. Flags rejected pushes and masters that
//                never respond.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_tx_queue #(
    parameter int DEPTH        = 8,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [6:0]               wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     master_busy,
    output logic [6:0]               addr2send,
    output logic [7:0]               data2send,
    output logic                     send,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int c_GW = $clog2(GAP_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(BUSY_TIMEOUT - 1);
    localparam logic [c_GW-1:0] c_GAP_INIT = c_GW'(GAP_CYCLES);
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [14:0]       r_mem [DEPTH];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_CW-1:0]   r_count;
    logic [c_TW-1:0]   r_tmo_cnt;
    logic [c_GW-1:0]   r_gap_cnt;
    logic [6:0]        r_addr;
    logic [7:0]        r_data;
    logic              r_send;
    logic              r_overflow;
    logic              r_timeout;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_send_nxt;
    logic              w_set_timeout;
    logic              w_gap_load;

    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    // A pop frees a slot on the same edge, so a full queue can still accept.
    assign w_push    = wr_en && (!w_full || w_pop);

    assign addr2send = r_addr;
    assign data2send = r_data;
    assign send      = r_send;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign timeout   = r_timeout;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_send_nxt    = r_send;
        w_set_timeout = 1'b0;
        w_gap_load    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_send_nxt  = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (master_busy) begin
                    w_send_nxt  = 1'b0;
                    w_state_nxt = S_WAIT;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    // Master never picked the entry up: drop it and cool down.
                    w_send_nxt    = 1'b0;
                    w_set_timeout = 1'b1;
                    w_gap_load    = 1'b1;
                    w_state_nxt   = S_GAP;
                end
            end
            S_WAIT: begin
                if (!master_busy) begin
                    w_gap_load  = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GW'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Entry storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wptr] <= {wr_addr, wr_data};
        end
    end

    // Pointers, occupancy, output registers, sticky flags and timers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_send     <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
            r_tmo_cnt  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_send <= w_send_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
                {r_addr, r_data} <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
            // SEND-cycle counter restarts with every issued entry
            if (w_pop) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_SEND && r_tmo_cnt != c_TMO_LAST) begin
                r_tmo_cnt <= r_tmo_cnt + c_TW'(1);
            end
            if (w_gap_load) begin
                r_gap_cnt <= c_GAP_INIT;
            end else if (r_state == S_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - c_GW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_tx_queue
//  Description : Randomized self-checking bench for i2c_tx_queue against a
//                queue-and-timestamp reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_tx_queue;

    localparam int DEPTH = 8;
    localparam int GAP   = 16;
    localparam int BT    = 1024;

    // Link availability as seen by the reference model
    localparam int c_FREE  = 0;
    localparam int c_OFFER = 1;
    localparam int c_XFER  = 2;
    localparam int c_COOL  = 3;

    logic       clk = 1'b0;
    logic       r_reset;
    logic       r_wr_en;
    logic [6:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_busy;
    logic [6:0] w_addr2send;
    logic [7:0] w_data2send;
    logic       w_send;
    logic       w_full;
    logic       w_empty;
    logic [3:0] w_count;
    logic       w_overflow;
    logic       w_timeout;

    always #5 clk = ~clk;

    i2c_tx_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) u_dut (
        .clk         (clk),
        .reset       (r_reset),
        .wr_en       (r_wr_en),
        .wr_addr     (r_wr_addr),
        .wr_data     (r_wr_data),
        .master_busy (r_busy),
        .addr2send   (w_addr2send),
        .data2send   (w_data2send),
        .send        (w_send),
        .full        (w_full),
        .empty       (w_empty),
        .count       (w_count),
        .overflow    (w_overflow),
        .timeout     (w_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [14:0] mq[$];
    int   cyc = 0;
    int   m_link = c_FREE;
    int   m_offer_t;
    int   m_resume_t;
    bit   m_send, m_ovf, m_to;
    logic [6:0] m_addr;
    logic [7:0] m_data;

    function automatic bit model_will_pop();
        return (m_link == c_FREE) && (mq.size() > 0);
    endfunction

    task automatic model_step();
        bit pop, push;
        cyc++;
        if (r_reset) begin
            mq.delete();
            m_link = c_FREE;
            m_send = 0; m_ovf = 0; m_to = 0;
            m_addr = '0; m_data = '0;
            return;
        end
        pop  = model_will_pop();
        push = r_wr_en && ((mq.size() < DEPTH) || pop);
        if (r_wr_en && !push) m_ovf = 1;
        case (m_link)
            c_FREE: if (pop) begin
                {m_addr, m_data} = mq.pop_front();
                m_send = 1;
                m_offer_t = cyc;
                m_link = c_OFFER;
            end
            c_OFFER: begin
                if (r_busy) begin
                    m_send = 0;
                    m_link = c_XFER;
                end else if (cyc - m_offer_t == BT) begin
                    m_send = 0;
                    m_to = 1;
                    m_resume_t = cyc + GAP;
                    m_link = c_COOL;
                end
            end
            c_XFER: if (!r_busy) begin
                m_resume_t = cyc + GAP;
                m_link = c_COOL;
            end
            default: if (cyc == m_resume_t) m_link = c_FREE;
        endcase
        if (push) mq.push_back({r_wr_addr, r_wr_data});
    endtask

    task automatic compare_all();
        check_val("count",    32'(w_count),     32'(mq.size()));
        check_val("full",     32'(w_full),      32'(mq.size() == DEPTH));
        check_val("empty",    32'(w_empty),     32'(mq.size() == 0));
        check_val("send",     32'(w_send),      32'(m_send));
        check_val("addr",     32'(w_addr2send), 32'(m_addr));
        check_val("data",     32'(w_data2send), 32'(m_data));
        check_val("overflow", 32'(w_overflow),  32'(m_ovf));
        check_val("timeout",  32'(w_timeout),   32'(m_to));
    endtask

    // ---------------- master model / delivery scoreboard ----------------
    int busy_mode = 0;        // 0 low, 1 high, 2 responsive
    int rsp_dly_cfg = 0;      // 0 selects a random value
    int rsp_len_cfg = 0;
    int rsp_wait = 0;
    int rsp_hold = 0;
    bit prev_send = 0;
    bit sb_on = 0;
    logic [14:0] sb[$];
    int delivered = 0;
    int send_rises = 0;

    task automatic drive_busy();
        if (busy_mode == 0) begin
            r_busy = 1'b0;
        end else if (busy_mode == 1) begin
            r_busy = 1'b1;
        end else if (rsp_hold > 0) begin
            rsp_hold--;
            if (rsp_hold == 0) r_busy = 1'b0;
        end else if (rsp_wait > 0) begin
            rsp_wait--;
            if (rsp_wait == 0) begin
                r_busy = 1'b1;
                rsp_hold = (rsp_len_cfg > 0) ? rsp_len_cfg : int'($urandom_range(1, 5));
            end
        end else if (w_send && !r_busy) begin
            rsp_wait = (rsp_dly_cfg > 0) ? rsp_dly_cfg : int'($urandom_range(1, 3));
        end
    endtask

    task automatic set_mode(input int mode);
        busy_mode = mode;
        rsp_wait = 0;
        rsp_hold = 0;
        r_busy = (mode == 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (w_send && !prev_send) begin
            send_rises++;
            if (sb_on) begin
                if (sb.size() == 0) begin
                    check_val("sb_unexpected", 32'({w_addr2send, w_data2send}), 32'h7fff_ffff);
                end else begin
                    check_val("sb_order", 32'({w_addr2send, w_data2send}), 32'(sb.pop_front()));
                    delivered++;
                end
            end
        end
        prev_send = w_send;
        drive_busy();
    endtask

    task automatic push_rand();
        r_wr_en   = 1'b1;
        r_wr_addr = 7'($urandom);
        r_wr_data = 8'($urandom);
    endtask

    task automatic do_reset();
        r_reset = 1'b1;
        r_wr_en = 1'b0;
        tick();
        r_reset = 1'b0;
    endtask

    // Bounds the whole run in case the DUT wedges
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        r_reset = 1'b1; r_wr_en = 1'b1; r_wr_addr = 7'h11; r_wr_data = 8'h22; r_busy = 1'b0;
        // reset wins over a simultaneous push
        tick(); tick();
        check_val("rst_count", 32'(w_count), 32'd0);
        check_val("rst_empty", 32'(w_empty), 32'd1);
        r_reset = 1'b0; r_wr_en = 1'b0;
        tick();

        // Single transaction with a 20-cycle busy pulse
        set_mode(2); rsp_dly_cfg = 2; rsp_len_cfg = 20;
        r_wr_en = 1'b1; r_wr_addr = 7'h50; r_wr_data = 8'hA5;
        tick();
        r_wr_en = 1'b0;
        check_val("t1_send_early", 32'(w_send), 32'd0);
        tick();
        check_val("t1_send", 32'(w_send), 32'd1);
        check_val("t1_addr", 32'(w_addr2send), 32'h50);
        check_val("t1_data", 32'(w_data2send), 32'hA5);
        for (int i = 0; i < 60; i++) tick();

        // Overfill with the master stuck busy
        set_mode(1);
        for (int i = 0; i < 10; i++) begin push_rand(); tick(); end
        r_wr_en = 1'b0;
        tick();
        check_val("t2_count", 32'(w_count), 32'd8);
        check_val("t2_full", 32'(w_full), 32'd1);
        check_val("t2_overflow", 32'(w_overflow), 32'd1);

        // Push coinciding exactly with a pop while full
        do_reset();
        set_mode(1);
        for (int i = 0; i < 9; i++) begin push_rand(); tick(); end
        r_wr_en = 1'b0;
        tick();
        check_val("t3_pre_count", 32'(w_count), 32'd8);
        set_mode(0);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (model_will_pop()) begin
                push_rand();
                hit = 1;
            end
            tick();
            r_wr_en = 1'b0;
        end
        check_val("t3_hit", 32'(hit), 32'd1);
        check_val("t3_count", 32'(w_count), 32'd8);
        check_val("t3_overflow", 32'(w_overflow), 32'd0);

        // Silent master: every entry times out in turn
        do_reset();
        set_mode(0);
        for (int i = 0; i < 3; i++) begin push_rand(); tick(); end
        r_wr_en = 1'b0;
        for (int i = 0; i < 3 * (BT + GAP + 2) + 20; i++) tick();
        check_val("t4_timeout", 32'(w_timeout), 32'd1);
        check_val("t4_empty", 32'(w_empty), 32'd1);

        // 20 entries through a responsive master, wrapping the pointers
        do_reset();
        set_mode(2); rsp_dly_cfg = 0; rsp_len_cfg = 0;
        sb_on = 1; delivered = 0;
        begin
            int pushed = 0;
            for (int i = 0; i < 4000 && !(pushed == 20 && sb.size() == 0); i++) begin
                if (pushed < 20 && ($urandom_range(0, 1) == 1) && (mq.size() < DEPTH)) begin
                    push_rand();
                    sb.push_back({r_wr_addr, r_wr_data});
                    pushed++;
                end else begin
                    r_wr_en = 1'b0;
                end
                tick();
            end
            r_wr_en = 1'b0;
        end
        check_val("t5_delivered", 32'(delivered), 32'd20);
        sb_on = 0;
        for (int i = 0; i < 40; i++) tick();

        // Reset while the master is mid-transaction
        set_mode(1);
        for (int i = 0; i < 5; i++) begin push_rand(); tick(); end
        r_wr_en = 1'b0;
        check_val("t6_pre_count", 32'(w_count), 32'd4);
        r_reset = 1'b1;
        tick();
        r_reset = 1'b0;
        set_mode(0);
        check_val("t6_count", 32'(w_count), 32'd0);
        check_val("t6_empty", 32'(w_empty), 32'd1);
        check_val("t6_send", 32'(w_send), 32'd0);
        send_rises = 0;
        for (int i = 0; i < 40; i++) tick();
        check_val("t6_no_send", 32'(send_rises), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
